clause_dispatch_fifo: RTL and testbench
=======================================

// Module: clause_dispatch_fifo
// PURPOSE
//  Clause buffer directly upstream of the clause arbiter. Accepts one clause per cycle from the
//  clause loader (valid/ready) and holds up to DEPTH clauses. Every cycle it presents the oldest
//  min(count,NUM_ENGINE) clauses as a window. It retires however many the arbiter accepts that cycle.
//  Supports a single-cycle flush, used when the solver backtracks or restarts.
// PARAMETERS
//  NUM_ENGINE     4    engines/arbiter lanes; window width
//  CLA_LENGTH     3    literals per clause
//  LIT_INDEX_MAX  16   max literal index; ELEM_W = $clog2(LIT_INDEX_MAX)+1 = 5
//  DEPTH          16   entries; power of 2, >= NUM_ENGINE
//  (derived) CLAUSE_W = CLA_LENGTH*ELEM_W = 15; CNT_W = $clog2(NUM_ENGINE)+1 = 3; OCC_W = $clog2(DEPTH)+1 = 5
// PORTS
//  clock          in   1                    single clock, rising edge
//  reset          in   1                    synchronous, active-high
//  push_valid     in   1                    loader has a clause
//  push_clause    in   CLAUSE_W             clause from loader
//  push_ready     out  1                    = !full; registered-state only, no dependence on pop_cnt
//  flush          in   1                    discard all contents (sync)
//  clause_out     out  NUM_ENGINE*CLAUSE_W  window; lane 0 = oldest; feeds arbiter clause_in
//  clause_cnt_out out  CNT_W                valid lanes = min(count,NUM_ENGINE); feeds arbiter clause_cnt_in
//  pop_cnt        in   CNT_W                clauses taken this cycle (arbiter clause_accept_out)
//  count          out  OCC_W                current occupancy
//  empty          out  1                    count==0
//  full           out  1                    count==DEPTH
//  pop_err        out  1                    sticky: pop_cnt exceeded clause_cnt_out
// BEHAVIOUR
//  - Storage: DEPTH x CLAUSE_W regs; rd_ptr/wr_ptr mod DEPTH; count register.
//  - Window is combinational from registered state: lane i = mem[(rd_ptr+i)%DEPTH] for i<clause_cnt_out, else 0.
//  - The arbiter closes the loop combinationally within one cycle: window -> arbiter -> pop_cnt.
//  - push_fire = push_valid & push_ready. A clause pushed in cycle N is visible in the window in cycle N+1.
//    There is no bypass.
//  - pop_eff = min(pop_cnt, clause_cnt_out). If pop_cnt > clause_cnt_out, clamp and set pop_err.
//    pop_err is cleared only by reset.
//  - On the clock edge: rd_ptr += pop_eff; wr_ptr += push_fire; count += push_fire - pop_eff.
//    Push and pop in the same cycle are both honoured.
//  - Full: push_ready=0 even if a pop occurs that cycle; held push_valid is not accepted and the data is not written.
//  - Empty: clause_cnt_out=0, window all zero; any nonzero pop_cnt sets pop_err and changes nothing.
//  - Pointer wrap at DEPTH is transparent; FIFO order is preserved across the wrap.
//  - flush: next cycle count=0, rd_ptr=wr_ptr=0. A push or pop in the flush cycle is discarded.
//    pop_err is retained. Storage contents need not be cleared.
//  - Priority: reset > flush > push/pop.
//  - Reset (any cycle, including mid-stream): count=0, pointers=0, pop_err=0.
//    Outputs after reset: empty=1, full=0, push_ready=1, clause_cnt_out=0, clause_out=0.
//  - Invariant: 0 <= count <= DEPTH; count never wraps.
// TESTING
//  1. Assert reset 2 cycles -> count=0, empty=1, push_ready=1, clause_cnt_out=0, clause_out all 0, pop_err=0.
//  2. Push A,B,C on 3 cycles with pop_cnt=0 -> clause_cnt_out=3, lanes=[A,B,C,0], count=3.
//  3. Push 6 clauses A..F, then one cycle with pop_cnt=4 -> next cycle count=2, lanes=[E,F,0,0], clause_cnt_out=2.
//  4. Push 16 clauses -> full=1, push_ready=0.
//     Hold push_valid with pop_cnt=1 -> count=15, new clause not stored; next cycle push accepted -> count=16.
//  5. Stream 40 clauses with random push_valid and pop_cnt in 0..clause_cnt_out -> output order matches input
//     across 2+ pointer wraps; count always equals pushes minus pops.
//  6. count=2, pop_cnt=5 -> 2 retired, empty=1, pop_err=1 and stays set.
//     Flush with count=9 and push_valid=1 -> count=0 next cycle, new push ignored.

Source files
------------

// File: rtl/clause_dispatch_fifo.sv
// Clause buffer feeding the clause arbiter. It accepts one clause per cycle and presents the
// oldest min(count, NUM_ENGINE) clauses as a window. It retires up to that many clauses per cycle.
module clause_dispatch_fifo #(
  parameter int unsigned NUM_ENGINE    = 4,
  parameter int unsigned CLA_LENGTH    = 3,
  parameter int unsigned LIT_INDEX_MAX = 16,
  parameter int unsigned DEPTH         = 16,
  localparam int unsigned ELEM_W   = $clog2(LIT_INDEX_MAX) + 1,
  localparam int unsigned CLAUSE_W = CLA_LENGTH * ELEM_W,
  localparam int unsigned CNT_W    = $clog2(NUM_ENGINE) + 1,
  localparam int unsigned OCC_W    = $clog2(DEPTH) + 1
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           push_valid,
  input  logic [CLAUSE_W-1:0]            push_clause,
  output logic                           push_ready,
  input  logic                           flush,
  output logic [NUM_ENGINE*CLAUSE_W-1:0] clause_out,
  output logic [CNT_W-1:0]               clause_cnt_out,
  input  logic [CNT_W-1:0]               pop_cnt,
  output logic [OCC_W-1:0]               count,
  output logic                           empty,
  output logic                           full,
  output logic                           pop_err
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [CLAUSE_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]    rd_ptr;
  logic [PTR_W-1:0]    wr_ptr;
  logic [CNT_W-1:0]    pop_eff;
  logic                pop_over;
  logic                push_fire;

  // Status flags come only from the occupancy register, so push_ready never depends on pop_cnt.
  assign empty      = (count == '0);
  assign full       = (count == OCC_W'(DEPTH));
  assign push_ready = ~full;
  assign push_fire  = push_valid & push_ready;

  // Window size, clamped pop and the over-pop error.
  always_comb begin
    clause_cnt_out = CNT_W'(NUM_ENGINE);
    if (count < OCC_W'(NUM_ENGINE)) begin
      clause_cnt_out = CNT_W'(count);
    end
    pop_over = (pop_cnt > clause_cnt_out);
    pop_eff  = pop_over ? clause_cnt_out : pop_cnt;
  end

  // Window lanes: lane 0 holds the oldest clause, and lanes past the valid count are zero.
  always_comb begin
    clause_out = '0;
    for (int unsigned i = 0; i < NUM_ENGINE; i++) begin
      if (CNT_W'(i) < clause_cnt_out) begin
        clause_out[i*CLAUSE_W +: CLAUSE_W] = mem[rd_ptr + PTR_W'(i)];
      end
    end
  end

  // Clause storage. No reset is needed because the window masks stale entries.
  always_ff @(posedge clock) begin
    if (!reset && !flush && push_fire) begin
      mem[wr_ptr] <= push_clause;
    end
  end

  // Pointers, occupancy and sticky error. Reset has priority over flush, and flush over push/pop.
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
      pop_err <= 1'b0;
    end else begin
      if (pop_over) begin
        pop_err <= 1'b1;
      end
      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        rd_ptr <= rd_ptr + PTR_W'(pop_eff);
        wr_ptr <= wr_ptr + PTR_W'(push_fire);
        count  <= count + OCC_W'(push_fire) - OCC_W'(pop_eff);
      end
    end
  end

endmodule

// File: tb/tb_clause_dispatch_fifo.sv
// Directed bench for clause_dispatch_fifo. It covers reset, window fill, multi-pop, full
// back-pressure, a randomized stream across pointer wraps, over-pop and flush.
module tb_clause_dispatch_fifo;

  localparam int unsigned CW = 15;
  localparam int unsigned NE = 4;

  logic              clock = 1'b0;
  logic              reset;
  logic              push_valid;
  logic [CW-1:0]     push_clause;
  logic              push_ready;
  logic              flush;
  logic [NE*CW-1:0]  clause_out;
  logic [2:0]        clause_cnt_out;
  logic [2:0]        pop_cnt;
  logic [4:0]        count;
  logic              empty;
  logic              full;
  logic              pop_err;

  int checks = 0;
  int errors = 0;

  clause_dispatch_fifo dut (
    .clock          (clock),
    .reset          (reset),
    .push_valid     (push_valid),
    .push_clause    (push_clause),
    .push_ready     (push_ready),
    .flush          (flush),
    .clause_out     (clause_out),
    .clause_cnt_out (clause_cnt_out),
    .pop_cnt        (pop_cnt),
    .count          (count),
    .empty          (empty),
    .full           (full),
    .pop_err        (pop_err)
  );

  always #5 clock = ~clock;

  function automatic logic [CW-1:0] mk(input int k);
    return CW'((k * 97 + 11) % 32768);
  endfunction

  // Advance one clock edge, then settle just after it so that outputs can be sampled.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    logic [NE*CW-1:0] zero_win;
    zero_win = '0;
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b exp 1", empty); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got %b exp 0", full); end
    checks++; if (push_ready !== 1'b1) begin errors++; $display("FAIL reset_push_ready got %b exp 1", push_ready); end
    checks++; if (clause_cnt_out !== 3'd0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", clause_cnt_out); end
    checks++; if (clause_out !== zero_win) begin errors++; $display("FAIL reset_window got %h exp 0", clause_out); end
    checks++; if (pop_err !== 1'b0) begin errors++; $display("FAIL reset_pop_err got %b exp 0", pop_err); end
  endtask

  task automatic do_flush();
    push_valid = 1'b0;
    pop_cnt    = 3'd0;
    flush      = 1'b1;
    step();
    flush = 1'b0;
  endtask

  task automatic test_push_three();
    logic [CW-1:0] lane;
    logic [CW-1:0] e [NE];
    e[0] = mk(0); e[1] = mk(1); e[2] = mk(2); e[3] = '0;
    for (int i = 0; i < 3; i++) begin
      push_valid  = 1'b1;
      push_clause = mk(i);
      step();
    end
    push_valid = 1'b0;
    checks++; if (clause_cnt_out !== 3'd3) begin errors++; $display("FAIL p3_cnt got %0d exp 3", clause_cnt_out); end
    checks++; if (count !== 5'd3) begin errors++; $display("FAIL p3_count got %0d exp 3", count); end
    for (int i = 0; i < NE; i++) begin
      lane = clause_out[i*CW +: CW];
      checks++; if (lane !== e[i]) begin errors++; $display("FAIL p3_lane%0d got %h exp %h", i, lane, e[i]); end
    end
    do_flush();
  endtask

  task automatic test_pop_window();
    logic [CW-1:0] lane;
    logic [CW-1:0] e [NE];
    for (int i = 0; i < 6; i++) begin
      push_valid  = 1'b1;
      push_clause = mk(10 + i);
      step();
    end
    push_valid = 1'b0;
    checks++; if (clause_cnt_out !== 3'd4) begin errors++; $display("FAIL pw_cnt_pre got %0d exp 4", clause_cnt_out); end
    lane = clause_out[3*CW +: CW];
    checks++; if (lane !== mk(13)) begin errors++; $display("FAIL pw_lane3_pre got %h exp %h", lane, mk(13)); end
    pop_cnt = 3'd4;
    step();
    pop_cnt = 3'd0;
    e[0] = mk(14); e[1] = mk(15); e[2] = '0; e[3] = '0;
    checks++; if (count !== 5'd2) begin errors++; $display("FAIL pw_count got %0d exp 2", count); end
    checks++; if (clause_cnt_out !== 3'd2) begin errors++; $display("FAIL pw_cnt got %0d exp 2", clause_cnt_out); end
    for (int i = 0; i < NE; i++) begin
      lane = clause_out[i*CW +: CW];
      checks++; if (lane !== e[i]) begin errors++; $display("FAIL pw_lane%0d got %h exp %h", i, lane, e[i]); end
    end
    do_flush();
  endtask

  task automatic test_full();
    logic [CW-1:0] lane;
    logic [CW-1:0] e [16];
    for (int i = 0; i < 16; i++) begin
      push_valid  = 1'b1;
      push_clause = mk(20 + i);
      step();
    end
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL full_flag got %b exp 1", full); end
    checks++; if (push_ready !== 1'b0) begin errors++; $display("FAIL full_ready got %b exp 0", push_ready); end
    checks++; if (count !== 5'd16) begin errors++; $display("FAIL full_count got %0d exp 16", count); end
    push_valid  = 1'b1;
    push_clause = mk(99);
    pop_cnt     = 3'd1;
    step();
    pop_cnt = 3'd0;
    checks++; if (count !== 5'd15) begin errors++; $display("FAIL full_pop_count got %0d exp 15", count); end
    checks++; if (push_ready !== 1'b1) begin errors++; $display("FAIL full_pop_ready got %b exp 1", push_ready); end
    step();
    push_valid = 1'b0;
    checks++; if (count !== 5'd16) begin errors++; $display("FAIL full_repush_count got %0d exp 16", count); end
    for (int i = 0; i < 15; i++) e[i] = mk(21 + i);
    e[15] = mk(99);
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < NE; i++) begin
        lane = clause_out[i*CW +: CW];
        checks++; if (lane !== e[r*4+i]) begin errors++; $display("FAIL full_drain%0d got %h exp %h", r*4+i, lane, e[r*4+i]); end
      end
      pop_cnt = 3'd4;
      step();
    end
    pop_cnt = 3'd0;
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL full_drain_empty got %b exp 1", empty); end
    do_flush();
  endtask

  task automatic test_stream();
    logic [CW-1:0] q [$];
    logic [CW-1:0] lane;
    logic [CW-1:0] ex;
    int pushed;
    int cyc;
    int exp_cnt;
    int pc;
    bit pv;
    bit fire;
    pushed = 0;
    cyc    = 0;
    while ((pushed < 40 || q.size() > 0) && cyc < 2000) begin
      exp_cnt = (q.size() < NE) ? q.size() : NE;
      checks++; if (count !== 5'(q.size())) begin errors++; $display("FAIL st_count cyc %0d got %0d exp %0d", cyc, count, q.size()); end
      checks++; if (clause_cnt_out !== 3'(exp_cnt)) begin errors++; $display("FAIL st_cnt cyc %0d got %0d exp %0d", cyc, clause_cnt_out, exp_cnt); end
      for (int i = 0; i < NE; i++) begin
        lane = clause_out[i*CW +: CW];
        ex   = (i < exp_cnt) ? q[i] : '0;
        checks++; if (lane !== ex) begin errors++; $display("FAIL st_lane%0d cyc %0d got %h exp %h", i, cyc, lane, ex); end
      end
      pv   = (pushed < 40) && ($urandom_range(0, 2) != 0);
      pc   = $urandom_range(0, exp_cnt);
      fire = pv && (q.size() < 16);
      push_valid  = pv;
      push_clause = mk(100 + pushed);
      pop_cnt     = 3'(pc);
      step();
      for (int k = 0; k < pc; k++) void'(q.pop_front());
      if (fire) begin
        q.push_back(mk(100 + pushed));
        pushed++;
      end
      cyc++;
    end
    push_valid = 1'b0;
    pop_cnt    = 3'd0;
    checks++; if (cyc >= 2000) begin errors++; $display("FAIL st_timeout got %0d cycles exp < 2000", cyc); end
  endtask

  task automatic test_pop_err_flush();
    for (int i = 0; i < 2; i++) begin
      push_valid  = 1'b1;
      push_clause = mk(200 + i);
      step();
    end
    push_valid = 1'b0;
    pop_cnt    = 3'd5;
    step();
    pop_cnt = 3'd0;
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL pe_count got %0d exp 0", count); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL pe_empty got %b exp 1", empty); end
    checks++; if (pop_err !== 1'b1) begin errors++; $display("FAIL pe_set got %b exp 1", pop_err); end
    pop_cnt = 3'd3;
    step();
    pop_cnt = 3'd0;
    step();
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL pe_empty_pop_count got %0d exp 0", count); end
    checks++; if (pop_err !== 1'b1) begin errors++; $display("FAIL pe_sticky got %b exp 1", pop_err); end
    for (int i = 0; i < 9; i++) begin
      push_valid  = 1'b1;
      push_clause = mk(210 + i);
      step();
    end
    checks++; if (count !== 5'd9) begin errors++; $display("FAIL fl_pre_count got %0d exp 9", count); end
    push_clause = mk(250);
    flush       = 1'b1;
    step();
    flush      = 1'b0;
    push_valid = 1'b0;
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL fl_count got %0d exp 0", count); end
    checks++; if (clause_cnt_out !== 3'd0) begin errors++; $display("FAIL fl_cnt got %0d exp 0", clause_cnt_out); end
    checks++; if (pop_err !== 1'b1) begin errors++; $display("FAIL fl_pop_err got %b exp 1", pop_err); end
    step();
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL fl_ignored_push got %b exp 1", empty); end
    push_valid  = 1'b1;
    push_clause = mk(260);
    step();
    push_valid = 1'b0;
    reset      = 1'b1;
    step();
    reset = 1'b0;
    checks++; if (pop_err !== 1'b0) begin errors++; $display("FAIL rst_pop_err got %b exp 0", pop_err); end
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL rst_mid_count got %0d exp 0", count); end
  endtask

  initial begin
    reset       = 1'b1;
    push_valid  = 1'b0;
    push_clause = '0;
    flush       = 1'b0;
    pop_cnt     = 3'd0;
    test_reset();
    test_push_three();
    test_pop_window();
    test_full();
    test_stream();
    test_pop_err_flush();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
